// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
//   state_t     : control FSM states (IDLE, ADD, SHIFT, HOLD)
//   count_width : iteration-counter width for a given operand width
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Counter must hold 0..width-1; keep at least one bit.
    function automatic int unsigned count_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_mult_addsub.sv
// (WIDTH+1)-bit adder/subtractor for one partial-product step.
// Ports:
//   i_a           : current A register (high half of the product)
//   i_s           : multiplicand S
//   i_sub         : 1 = A - S, 0 = A + S
//   i_signed_mode : 1 = sign-extend operands, 0 = zero-extend
//   o_sum_c       : {X, A} result (combinational)
module seq_mult_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_s,
    input  logic             i_sub,
    input  logic             i_signed_mode,
    output logic [WIDTH:0]   o_sum_c
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_s_ext;

    // Extension bit is the sign in signed mode, the carry slot otherwise.
    always_comb begin
        w_a_ext = {i_signed_mode & i_a[WIDTH-1], i_a};
        w_s_ext = {i_signed_mode & i_s[WIDTH-1], i_s};
        o_sum_c = i_sub ? (w_a_ext - w_s_ext) : (w_a_ext + w_s_ext);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Parametrised sequential shift-add multiplier (signed/unsigned).
// The product is left in A:B so repeated Execute presses chain multiplies.
// Ports:
//   Clk, Reset (async, active-low)
//   Execute, Load_B, Clear_A, Signed_Mode, Din[WIDTH-1:0] : controls/operand
//   Aval, Bval : product high/low halves; X : extension bit of A
//   Busy : high in ADD/SHIFT; Done : one-cycle pulse on HOLD entry
// Optional: define SEQ_MULT_OP_COUNT_EN to add Op_Count[15:0], a saturating
// count of completed operations cleared by Reset and Clear_A.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Execute,
    input  logic             Load_B,
    input  logic             Clear_A,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] Din,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
`ifdef SEQ_MULT_OP_COUNT_EN
    ,
    output logic [15:0]      Op_Count
`endif
);

    localparam int unsigned CNT_W = count_width(WIDTH);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_x;
    logic               r_mode;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy;
    logic               r_done;

    logic               w_last;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;

    // Last iteration carries the negative weight of the signed multiplier MSB.
    assign w_last = (r_count == CNT_W'(WIDTH - 1));
    assign w_sub  = r_mode & w_last;

    seq_mult_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .i_a           (r_a),
        .i_s           (r_s),
        .i_sub         (w_sub),
        .i_signed_mode (r_mode),
        .o_sum_c       (w_sum)
    );

`ifdef SEQ_MULT_OP_COUNT_EN
    logic [15:0] r_op_count;
    assign Op_Count = r_op_count;
`endif

    // Control FSM and A/B/X shift registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_x     <= 1'b0;
            r_mode  <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SEQ_MULT_OP_COUNT_EN
            r_op_count <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, HOLD: begin
                    if (Load_B) begin
                        r_b <= Din;
                    end
                    if (Clear_A) begin
                        r_a <= '0;
                        r_x <= 1'b0;
`ifdef SEQ_MULT_OP_COUNT_EN
                        r_op_count <= '0;
`endif
                    end
                    // Execute is only honoured when no register load is pending.
                    if (!Load_B && !Clear_A) begin
                        if (r_state == IDLE) begin
                            if (Execute) begin
                                r_s     <= Din;
                                r_mode  <= Signed_Mode;
                                r_a     <= '0;
                                r_x     <= 1'b0;
                                r_count <= '0;
                                r_busy  <= 1'b1;
                                r_state <= ADD;
                            end
                        end else if (!Execute) begin
                            r_state <= IDLE;
                        end
                    end
                end
                ADD: begin
                    if (r_b[0]) begin
                        {r_x, r_a} <= w_sum;
                    end
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_a <= {r_x, r_a[WIDTH-1:1]};
                    r_b <= {r_a[0], r_b[WIDTH-1:1]};
                    // Signed: arithmetic shift keeps X; unsigned: carry consumed.
                    if (!r_mode) begin
                        r_x <= 1'b0;
                    end
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_state <= HOLD;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`ifdef SEQ_MULT_OP_COUNT_EN
                        if (r_op_count != 16'hFFFF) begin
                            r_op_count <= r_op_count + 16'd1;
                        end
`endif
                    end else begin
                        r_state <= ADD;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign Aval = r_a;
    assign Bval = r_b;
    assign X    = r_x;
    assign Busy = r_busy;
    assign Done = r_done;

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier, successor to the fixed 8-bit switch-driven multiplier.
- Supports signed (two's-complement, subtract on last partial product) and unsigned mode, WIDTH-generic datapath, Busy/Done status.
- Product stays in the A:B registers, so repeated Execute presses chain multiplications.
- Sits between the switch/button synchronisers and the hex display driver.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH. Legal range 4..32.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- Execute  in  1  level; start one multiplication, then hold until released.
- Load_B  in  1  level; B <= Din (IDLE/HOLD only).
- Clear_A  in  1  level; A <= 0, X <= 0 (IDLE/HOLD only).
- Signed_Mode  in  1  1 = signed multiply, 0 = unsigned; sampled at start.
- Din  in  WIDTH  operand input (multiplicand S at start, multiplier via Load_B).
- Aval  out  WIDTH  A register (product high half).
- Bval  out  WIDTH  B register (product low half).
- X  out  1  sign/carry extension bit of A.
- Busy  out  1  high in ADD/SHIFT states.
- Done  out  1  one-cycle pulse on entry to HOLD.

Behaviour:
- Reset low (any time, including mid-operation): A, B, X, S, count, mode latch cleared to 0; state IDLE; Busy = 0; Done = 0.
- States:
  - IDLE: waits for Execute.
  - ADD: conditional add/subtract.
  - SHIFT: right shift of the extended A:B register.
  - HOLD: waits for Execute to be released.
- Priority in IDLE/HOLD: Load_B > Clear_A > Execute. While Load_B or Clear_A is high, Execute is not accepted that cycle. Both Load_B and Clear_A high: both actions apply.
- Start (IDLE, Execute = 1, Load_B = Clear_A = 0, at edge k):
  - S <= Din; mode <= Signed_Mode; A <= 0; X <= 0; count <= 0; go to ADD.
  - B is kept, which gives chaining.
- ADD:
  - If B[0] = 1: {X,A} <= {A_ext} + {S_ext}.
  - On the last iteration (count = WIDTH-1) in signed mode, subtract S instead of adding.
  - Signed: sign-extend A and S to WIDTH+1 bits. Unsigned: zero-extend; X takes the carry-out.
  - If B[0] = 0: no change.
  - Always go to SHIFT.
- SHIFT:
  - A <= {X, A[WIDTH-1:1]}; B <= {A[0], B[WIDTH-1:1]}.
  - X unchanged in signed mode; X <= 0 in unsigned mode.
  - count++. If count was WIDTH-1, go to HOLD, else go to ADD.
- Latency: exactly 2*WIDTH cycles from the start edge to the HOLD entry edge. Done is high for the first HOLD cycle only.
- HOLD: stays while Execute = 1; returns to IDLE when Execute = 0. The result stays stable.
- During ADD/SHIFT: Load_B, Clear_A, Din, Signed_Mode and Execute are ignored.
- Result: {Aval,Bval} = S*B_initial, mod 2^(2*WIDTH), signed or unsigned per mode. X equals Aval[WIDTH-1] in signed mode and 0 in unsigned mode.
- Edge cases:
  - B = 0 gives 0.
  - S = most negative, B = most negative (signed) gives the correct positive product (fits 2*WIDTH).

Optional Feature:
- Macro: SEQ_MULT_OP_COUNT_EN.
- Defined: adds output Op_Count [15:0]. Increments on each Done pulse, saturates at 16'hFFFF, cleared by Reset and by Clear_A.
- Undefined: port absent; no counter logic.

Decomposition:
- Package seq_mult_pkg: state enum typedef (IDLE, ADD, SHIFT, HOLD) and the count-width function $clog2(WIDTH).
- Sub-module seq_mult_addsub: WIDTH+1-bit adder/subtractor.
  - Inputs: A, S, sub, signed_mode.
  - Outputs: {X,A} sum.
- Control FSM and shift registers live in the top module.

Test Plan:
- WIDTH=8, signed: Load_B with Din=8'hBF, then Execute with Din=8'hED -> after 16 cycles Done pulses, Aval=8'h04, Bval=8'hD3, X=1'b0.
- Same operands, Signed_Mode=0 -> Aval=8'hB0, Bval=8'hD3, X=0.
- Chaining: from 8'h04/8'hD3, release Execute, Din=8'h02, Execute (signed) -> Aval=8'hFF, Bval=8'hA6.
- WIDTH=16, signed: B=16'h8000, S=16'h7FFF -> Aval=16'hC000, Bval=16'h8000, latency 32 cycles.
- Reset pulsed low at cycle 5 of an operation -> all outputs 0, state IDLE. Execute held high through reset release starts a new operation, which completes normally.
- Execute held 40 cycles: exactly one operation and one Done pulse; Load_B asserted during Busy leaves B unchanged. With SEQ_MULT_OP_COUNT_EN defined, Op_Count increments by 1 per operation.
